// File: rtl/xt_lb_bridge_pkg.sv
// rtl/xt_lb_bridge_pkg.sv - shared types and constants for the HB-to-LB bridge
package xt_lb_bridge_pkg;

    localparam int LB_ADDR_MAX = 32;
    localparam int LB_DATA_MAX = 64;
    localparam logic [LB_DATA_MAX-1:0] LB_ERR_RDATA = '1;

    typedef enum logic [1:0] {
        LB_IDLE,
        LB_READ,
        LB_WRITE,
        LB_DONE
    } lb_bridge_state_e;

    // Sized for the widest bus; instances use the low ADDR_WIDTH/DATA_WIDTH bits.
    typedef struct packed {
        logic [LB_ADDR_MAX-1:0] raddr;
        logic [LB_ADDR_MAX-1:0] waddr;
        logic [LB_DATA_MAX-1:0] wdata;
        logic [1:0]             width;
        logic                   ren;
        logic                   wen;
    } lb_req_t;

endpackage

// File: rtl/xt_lb_watchdog.sv
// rtl/xt_lb_watchdog.sv - wait-state counter flagging the last permitted cycle
module xt_lb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A zero timeout leaves the counter free-running but never reports expiry.
    assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/xt_lb_bridge.sv
// rtl/xt_lb_bridge.sv - one HB access to LB strobes with slave select, wait states and timeout
module xt_lb_bridge
    import xt_lb_bridge_pkg::*;
#(
    parameter int SLAVE_NUM      = 4,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  hb_clk,
    input  logic                  rst,
    input  logic                  hb_ren,
    input  logic                  hb_wen,
    input  logic [ADDR_WIDTH-1:0] hb_raddr,
    input  logic [ADDR_WIDTH-1:0] hb_waddr,
    input  logic [DATA_WIDTH-1:0] hb_wdata,
    input  logic [1:0]            hb_write_width,
    output logic                  hb_busy,
    output logic [DATA_WIDTH-1:0] hb_rdata,
    output logic                  hb_read_finish,
    output logic                  hb_write_finish,
    output logic                  hb_error,
    output logic                  lb_ren,
    output logic                  lb_wen,
    output logic [ADDR_WIDTH-1:0] lb_addr,
    output logic [DATA_WIDTH-1:0] lb_wdata,
    output logic [1:0]            lb_write_width,
    output logic [SLAVE_NUM-1:0]  lb_sel,
    input  logic [DATA_WIDTH-1:0] lb_data_in [SLAVE_NUM],
    input  logic [SLAVE_NUM-1:0]  lb_ready
);

    localparam int IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

    lb_bridge_state_e r_state;
    lb_bridge_state_e w_next;
    lb_req_t          r_req;
    logic             r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_idx_ok;
    logic                  w_active;
    logic                  w_rdy;
    logic                  w_expired;
    logic                  w_unused;

    assign w_raddr  = r_req.raddr[ADDR_WIDTH-1:0];
    assign w_waddr  = r_req.waddr[ADDR_WIDTH-1:0];
    assign w_active = (r_state == LB_READ) || (r_state == LB_WRITE);
    assign w_addr   = (r_state == LB_WRITE) ? w_waddr : w_raddr;
    assign w_idx    = w_addr[ADDR_WIDTH-1 -: IDX_W];
    assign w_idx_ok = (32'(w_idx) < SLAVE_NUM);
    // Only the selected slave's ready counts; others may toggle freely.
    assign w_rdy    = w_idx_ok && lb_ready[w_idx];
    assign w_unused = ^{r_req.raddr, r_req.waddr, r_req.wdata};

    xt_lb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (hb_clk),
        .rst       (rst),
        .i_clear   (w_next != r_state),
        .i_enable  (w_active),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            LB_IDLE: begin
                if (hb_ren) begin
                    w_next = LB_READ;
                end else if (hb_wen) begin
                    w_next = LB_WRITE;
                end
            end
            LB_READ: begin
                if (!w_idx_ok) begin
                    w_next = LB_DONE;
                end else if (w_rdy) begin
                    w_next = r_req.wen ? LB_WRITE : LB_DONE;
                end else if (w_expired) begin
                    w_next = LB_DONE;
                end
            end
            LB_WRITE: begin
                if (!w_idx_ok || w_rdy || w_expired) begin
                    w_next = LB_DONE;
                end
            end
            default: w_next = LB_IDLE;
        endcase
    end

    always_ff @(posedge hb_clk or posedge rst) begin
        if (rst) begin
            r_state <= LB_IDLE;
            r_req   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                LB_IDLE: begin
                    if (hb_ren || hb_wen) begin
                        r_req.raddr <= LB_ADDR_MAX'(hb_raddr);
                        r_req.waddr <= LB_ADDR_MAX'(hb_waddr);
                        r_req.wdata <= LB_DATA_MAX'(hb_wdata);
                        r_req.width <= hb_write_width;
                        r_req.ren   <= hb_ren;
                        r_req.wen   <= hb_wen;
                        r_err       <= 1'b0;
                    end
                end
                LB_READ: begin
                    if (!w_idx_ok || (!w_rdy && w_expired)) begin
                        r_err   <= 1'b1;
                        r_rdata <= LB_ERR_RDATA[DATA_WIDTH-1:0];
                    end else if (w_rdy) begin
                        r_rdata <= lb_data_in[w_idx];
                    end
                end
                LB_WRITE: begin
                    if (!w_idx_ok || (!w_rdy && w_expired)) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hb_busy         = (r_state != LB_IDLE);
    assign hb_rdata        = r_rdata;
    assign hb_read_finish  = (r_state == LB_DONE) && r_req.ren;
    assign hb_write_finish = (r_state == LB_DONE) && r_req.wen;
    assign hb_error        = (r_state == LB_DONE) && r_err;

    assign lb_ren         = (r_state == LB_READ) && w_idx_ok;
    assign lb_wen         = (r_state == LB_WRITE) && w_idx_ok;
    assign lb_sel         = (w_active && w_idx_ok) ? (SLAVE_NUM'(1) << w_idx) : '0;
    assign lb_addr        = w_active ? w_addr : '0;
    assign lb_wdata       = r_req.wdata[DATA_WIDTH-1:0];
    assign lb_write_width = r_req.width;

endmodule
